// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation engine: register map,
// control/status bit positions, FSM states and operand byte-count helper.
package rsa_pkg;

  localparam int unsigned OFS_STATUS = 0;
  localparam int unsigned OFS_CTRL   = 1;
  localparam int unsigned OFS_OPS    = 2;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_DONE    = 1;
  localparam int unsigned ST_ERR     = 2;

  localparam int unsigned CT_START   = 0;
  localparam int unsigned CT_ABORT   = 1;
  localparam int unsigned CT_IRQ_EN  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SQ     = 3'd2,
    MUL    = 3'd3,
    FINISH = 3'd4
  } state_e;

  function automatic int unsigned nb_calc(input int unsigned width, input int unsigned reg_w);
    return (width + reg_w - 1) / reg_w;
  endfunction

endpackage

// File: rtl/rsa_modmul_serial.sv
// Bit-serial interleaved modular multiplier: r = a*b mod p over WIDTH cycles,
// MSB first. done and r are valid in the cycle that processes bit 0.
module rsa_modmul_serial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] r,
  output logic             done
);

  localparam int unsigned AW    = WIDTH + 2;
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic [AW-1:0]    acc_r;
  logic [IDX_W-1:0] j_r;
  logic             active_r;
  logic [IDX_W-1:0] idx_s;
  logic [AW-1:0]    base_s, sum_s, red1_s, red2_s, pw_s;
  logic             step_s;

  // One shift-add step, then at most two subtractions bring acc back below p
  always_comb begin
    pw_s   = AW'(p);
    step_s = start | active_r;
    idx_s  = start ? IDX_W'(WIDTH - 1) : j_r;
    base_s = start ? {AW{1'b0}} : acc_r;
    sum_s  = {base_s[AW-2:0], 1'b0} + (a[idx_s] ? AW'(b) : {AW{1'b0}});
    if (sum_s >= pw_s) red1_s = sum_s - pw_s;
    else               red1_s = sum_s;
    if (red1_s >= pw_s) red2_s = red1_s - pw_s;
    else                red2_s = red1_s;
    done = step_s && (idx_s == {IDX_W{1'b0}});
    r    = red2_s[WIDTH-1:0];
  end

  // Accumulator and bit index advance only while a product is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= {AW{1'b0}};
      j_r      <= {IDX_W{1'b0}};
      active_r <= 1'b0;
    end else if (step_s) begin
      acc_r    <= red2_s;
      j_r      <= idx_s - IDX_W'(1);
      active_r <= !done;
    end else begin
      active_r <= 1'b0;
    end
  end

endmodule

// File: rtl/rsa_modexp_engine.sv
// Register-mapped C = M^E mod P engine: left-to-right square-and-multiply
// driving one serial modular multiplier, with start/abort, status and irq.
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned REG_W      = 8,
  parameter int unsigned ADDR_W     = 4,
  parameter bit          CONST_TIME = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [REG_W-1:0]  reg_wdata,
  input  logic              reg_we,
  output logic [REG_W-1:0]  reg_rdata,
  output logic              busy,
  output logic              irq
);

  localparam int unsigned NB    = nb_calc(WIDTH, REG_W);
  localparam int unsigned PADW  = NB * REG_W;
  localparam int unsigned IDX_W = $clog2(WIDTH);

  if ((2 ** ADDR_W) < (2 + 4 * NB) || WIDTH < 4) begin : g_bad_params
    $error("rsa_modexp_engine: address space too small for operands or WIDTH < 4");
  end

  function automatic logic [REG_W-1:0] get_byte(input logic [WIDTH-1:0] v, input int unsigned idx);
    logic [PADW-1:0] pad;
    pad = PADW'(v);
    return REG_W'(pad >> (idx * REG_W));
  endfunction

  function automatic logic [WIDTH-1:0] put_byte(input logic [WIDTH-1:0] v, input int unsigned idx,
                                                input logic [REG_W-1:0] d);
    logic [PADW-1:0] pad, mask;
    pad  = PADW'(v);
    mask = PADW'({REG_W{1'b1}}) << (idx * REG_W);
    pad  = (pad & ~mask) | (PADW'(d) << (idx * REG_W));
    return pad[WIDTH-1:0];
  endfunction

  state_e             state_r, state_n;
  logic               busy_r, mm_start_r, mm_start_n;
  logic [WIDTH-1:0]   p_r, e_r, m_r, c_r, r_r;
  logic [IDX_W-1:0]   bit_i_r;
  logic               done_r, err_r, irq_en_r, irq_r;
  logic [ADDR_W-1:0]  rel_s;
  logic               in_ops_s, wr_ctrl_s, wr_status_s, start_req_s, abort_req_s;
  int unsigned        op_s, byte_s;
  logic               advance_s, load_one_s, load_mm_s, load_c_s, c_zero_s, dec_i_s;
  logic               set_fail_s, set_done_s, clr_status_s;
  logic [WIDTH-1:0]   mm_b_s, mm_r_s;
  logic               mm_done_s;
  logic [REG_W-1:0]   rdata_s;

  // Address decode shared by the write and read paths
  always_comb begin
    rel_s       = reg_addr - ADDR_W'(OFS_OPS);
    in_ops_s    = (reg_addr >= ADDR_W'(OFS_OPS)) && (32'(rel_s) < 4 * NB);
    op_s        = 32'(rel_s) / NB;
    byte_s      = 32'(rel_s) % NB;
    wr_ctrl_s   = reg_we && (reg_addr == ADDR_W'(OFS_CTRL));
    wr_status_s = reg_we && (reg_addr == ADDR_W'(OFS_STATUS));
    abort_req_s = wr_ctrl_s && reg_wdata[CT_ABORT];
    start_req_s = wr_ctrl_s && reg_wdata[CT_START] && !reg_wdata[CT_ABORT];
  end

  // Control FSM next-state and datapath strobes; abort wins in every busy state
  always_comb begin
    state_n      = state_r;
    mm_start_n   = 1'b0;
    advance_s    = 1'b0;
    load_one_s   = 1'b0;
    load_mm_s    = 1'b0;
    load_c_s     = 1'b0;
    c_zero_s     = 1'b0;
    dec_i_s      = 1'b0;
    set_fail_s   = 1'b0;
    set_done_s   = 1'b0;
    clr_status_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_req_s) begin
          state_n      = CHECK;
          clr_status_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      CHECK: begin
        if (abort_req_s) begin
          state_n = IDLE;
        end else if (p_r < WIDTH'(2) || m_r >= p_r) begin
          set_fail_s = 1'b1;
          set_done_s = 1'b1;
          c_zero_s   = 1'b1;
          state_n    = IDLE;
        end else begin
          load_one_s = 1'b1;
          mm_start_n = 1'b1;
          state_n    = SQ;
        end
      end
      SQ: begin
        if (abort_req_s) begin
          state_n = IDLE;
        end else if (mm_done_s) begin
          load_mm_s = 1'b1;
          if (!CONST_TIME && !e_r[bit_i_r]) begin
            advance_s = 1'b1;
          end else begin
            state_n    = MUL;
            mm_start_n = 1'b1;
          end
        end else begin
          state_n = SQ;
        end
      end
      MUL: begin
        if (abort_req_s) begin
          state_n = IDLE;
        end else if (mm_done_s) begin
          load_mm_s = e_r[bit_i_r];
          advance_s = 1'b1;
        end else begin
          state_n = MUL;
        end
      end
      FINISH: begin
        if (abort_req_s) begin
          state_n = IDLE;
        end else begin
          load_c_s   = 1'b1;
          set_done_s = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (advance_s) begin
      if (bit_i_r == {IDX_W{1'b0}}) begin
        state_n = FINISH;
      end else begin
        dec_i_s    = 1'b1;
        mm_start_n = 1'b1;
        state_n    = SQ;
      end
    end else begin
      dec_i_s = 1'b0;
    end
  end

  // FSM state, multiplier kick and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      mm_start_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      mm_start_r <= mm_start_n;
      busy_r     <= (state_n != IDLE);
    end
  end

  // Register file, exponent bit index, running result and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r      <= {WIDTH{1'b0}};
      e_r      <= {WIDTH{1'b0}};
      m_r      <= {WIDTH{1'b0}};
      c_r      <= {WIDTH{1'b0}};
      r_r      <= {WIDTH{1'b0}};
      bit_i_r  <= {IDX_W{1'b0}};
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      irq_en_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (reg_we && in_ops_s && !busy_r) begin
        case (op_s)
          32'd0:   p_r <= put_byte(p_r, byte_s, reg_wdata);
          32'd1:   e_r <= put_byte(e_r, byte_s, reg_wdata);
          32'd2:   m_r <= put_byte(m_r, byte_s, reg_wdata);
          default: ;
        endcase
      end
      if (wr_ctrl_s) irq_en_r <= reg_wdata[CT_IRQ_EN];
      if (wr_status_s && reg_wdata[ST_DONE]) done_r <= 1'b0;
      if (wr_status_s && reg_wdata[ST_ERR])  err_r  <= 1'b0;
      if (clr_status_s) begin
        done_r <= 1'b0;
        err_r  <= 1'b0;
      end
      if (set_done_s) done_r <= 1'b1;
      if (set_fail_s) err_r  <= 1'b1;
      if (load_one_s) begin
        r_r     <= WIDTH'(1);
        bit_i_r <= IDX_W'(WIDTH - 1);
      end
      if (load_mm_s) r_r <= mm_r_s;
      if (dec_i_s)   bit_i_r <= bit_i_r - IDX_W'(1);
      if (load_c_s)  c_r <= r_r;
      if (c_zero_s)  c_r <= {WIDTH{1'b0}};
      irq_r <= done_r & irq_en_r;
    end
  end

  assign mm_b_s = (state_r == SQ) ? r_r : m_r;

  rsa_modmul_serial #(.WIDTH(WIDTH)) u_modmul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mm_start_r),
    .a     (r_r),
    .b     (mm_b_s),
    .p     (p_r),
    .r     (mm_r_s),
    .done  (mm_done_s)
  );

  // Combinational read mux; start/abort always read back as 0
  always_comb begin
    rdata_s = {REG_W{1'b0}};
    if (reg_addr == ADDR_W'(OFS_STATUS)) begin
      rdata_s[ST_BUSY] = busy_r;
      rdata_s[ST_DONE] = done_r;
      rdata_s[ST_ERR]  = err_r;
    end else if (reg_addr == ADDR_W'(OFS_CTRL)) begin
      rdata_s[CT_IRQ_EN] = irq_en_r;
    end else if (in_ops_s) begin
      case (op_s)
        32'd0:   rdata_s = get_byte(p_r, byte_s);
        32'd1:   rdata_s = get_byte(e_r, byte_s);
        32'd2:   rdata_s = get_byte(m_r, byte_s);
        32'd3:   rdata_s = get_byte(c_r, byte_s);
        default: rdata_s = {REG_W{1'b0}};
      endcase
    end else begin
      rdata_s = {REG_W{1'b0}};
    end
  end

  assign reg_rdata = rdata_s;
  assign busy      = busy_r;
  assign irq       = irq_r;

endmodule
